// File: rtl/escalonador_pkg.sv
// Shared definitions for the enemy shot scheduler: FSM encoding and
// the constants used when the cooldown speeds up as enemies die.
package escalonador_pkg;

    typedef enum logic [1:0] {
        ESPERA  = 2'd0,
        ESCOLHE = 2'd1,
        DISPARA = 2'd2
    } estado_t;

    localparam int PASSO_ACELERA = 8;
    localparam int PISO_ACELERA  = 8;

endpackage

// File: rtl/escalonador_tiro_rr_arbitro.sv
// Combinational round-robin picker: first set request after 'ultimo',
// wrapping around, with 'ultimo' itself considered last.
module rr_arbitro #(
    parameter int N_INIMIGOS = 5
) (
    input  logic [N_INIMIGOS-1:0] pedidos,
    input  logic [2:0]            ultimo,
    output logic [2:0]            escolhido,
    output logic                  valido
);

    // Scan from the farthest offset down so the nearest candidate wins.
    always_comb begin
        int j;
        j         = 0;
        escolhido = ultimo;
        valido    = 1'b0;
        for (int k = N_INIMIGOS; k >= 1; k--) begin
            j = (int'(ultimo) + k) % N_INIMIGOS;
            if (pedidos[j]) begin
                escolhido = 3'(j);
                valido    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/escalonador_tiro.sv
// Enemy shot scheduler for one row: cooldown, round-robin grant, held request.
// Optional macro ESCALONADOR_ACELERA_EN shortens the cooldown as enemies die.
module escalonador_tiro
    import escalonador_pkg::*;
#(
    parameter int N_INIMIGOS = 5,
    parameter int COOLDOWN   = 60,
    parameter int W_CD       = 8,
    parameter int TIMEOUT    = 4
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  reiniciarJogo,
    input  logic                  pausa,
    input  logic                  tick_mv,
    input  logic [N_INIMIGOS-1:0] vivo,
    input  logic [N_INIMIGOS-1:0] bola_livre,
    output logic [N_INIMIGOS-1:0] disparo,
    output logic [2:0]            idx_atual,
    output logic                  ocupado
);

    localparam int W_TO = $clog2(TIMEOUT + 1);

    estado_t               estado;
    logic [W_CD-1:0]       cnt_cd;
    logic [W_TO-1:0]       cnt_to;
    logic [W_CD-1:0]       carga_cd;
    logic [N_INIMIGOS-1:0] candidatos;
    logic [2:0]            escolhido;
    logic                  valido;
    logic                  sai_disparo;

    assign candidatos = vivo & bola_livre;

    rr_arbitro #(
        .N_INIMIGOS(N_INIMIGOS)
    ) u_arbitro (
        .pedidos  (candidatos),
        .ultimo   (idx_atual),
        .escolhido(escolhido),
        .valido   (valido)
    );

`ifdef ESCALONADOR_ACELERA_EN
    // Each dead enemy takes one step off the cooldown, never below the floor.
    always_comb begin
        int valor;
        valor = COOLDOWN - PASSO_ACELERA * (N_INIMIGOS - $countones(vivo));
        if (valor < PISO_ACELERA) begin
            valor = PISO_ACELERA;
        end
        carga_cd = W_CD'(valor);
    end
`else
    assign carga_cd = W_CD'(COOLDOWN);
`endif

    // Dead target wins over acceptance; both end the grant identically anyway.
    assign sai_disparo = !vivo[idx_atual] || !bola_livre[idx_atual] ||
                         (tick_mv && (cnt_to == W_TO'(TIMEOUT - 1)));

    always_ff @(posedge CLOCK_50) begin
        if (reset || reiniciarJogo) begin
            estado    <= ESPERA;
            cnt_cd    <= W_CD'(COOLDOWN);
            cnt_to    <= '0;
            disparo   <= '0;
            idx_atual <= 3'(N_INIMIGOS - 1);
            ocupado   <= 1'b1;
        end else if (!pausa) begin
            case (estado)
                ESPERA: begin
                    if (tick_mv) begin
                        if (cnt_cd <= W_CD'(1)) begin
                            cnt_cd  <= '0;
                            estado  <= ESCOLHE;
                            ocupado <= 1'b0;
                        end else begin
                            cnt_cd <= cnt_cd - W_CD'(1);
                        end
                    end
                end
                ESCOLHE: begin
                    if (valido) begin
                        idx_atual <= escolhido;
                        disparo   <= {{(N_INIMIGOS-1){1'b0}}, 1'b1} << escolhido;
                        cnt_to    <= '0;
                        estado    <= DISPARA;
                        ocupado   <= 1'b1;
                    end
                end
                DISPARA: begin
                    if (sai_disparo) begin
                        disparo <= '0;
                        cnt_cd  <= carga_cd;
                        estado  <= ESPERA;
                    end else if (tick_mv) begin
                        cnt_to <= cnt_to + W_TO'(1);
                    end
                end
                default: begin
                    estado  <= ESPERA;
                    cnt_cd  <= W_CD'(COOLDOWN);
                    disparo <= '0;
                    ocupado <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_escalonador_tiro.sv
// Self-checking bench for escalonador_tiro: behavioural model compared every
// cycle, plus directed literal checks of grants and cooldown lengths.
module tb_escalonador_tiro;

    localparam int N        = 5;
    localparam int COOLDOWN = 60;
    localparam int TIMEOUT  = 4;

`ifdef ESCALONADOR_ACELERA_EN
    localparam int CD_DOIS   = 36;
    localparam int CD_QUATRO = 52;
`else
    localparam int CD_DOIS   = 60;
    localparam int CD_QUATRO = 60;
`endif

    logic         CLOCK_50;
    logic         reset;
    logic         reiniciarJogo;
    logic         pausa;
    logic         tick_mv;
    logic [N-1:0] vivo;
    logic [N-1:0] bola_livre;
    logic [N-1:0] disparo;
    logic [2:0]   idx_atual;
    logic         ocupado;

    int checks;
    int errors;
    bit chk_en;

    escalonador_tiro dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .reiniciarJogo(reiniciarJogo),
        .pausa        (pausa),
        .tick_mv      (tick_mv),
        .vivo         (vivo),
        .bola_livre   (bola_livre),
        .disparo      (disparo),
        .idx_atual    (idx_atual),
        .ocupado      (ocupado)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #10 CLOCK_50 = ~CLOCK_50;
    end

    // Model: phase 0 = waiting, 1 = choosing, 2 = holding a shot.
    typedef struct {
        int fase;
        int resta;
        int ticks;
        int idx;
        bit fire;
    } model_t;

    model_t m = '{fase: 0, resta: COOLDOWN, ticks: 0, idx: N - 1, fire: 1'b0};

    function automatic int cd_load(logic [N-1:0] v);
        int val;
        val = COOLDOWN;
`ifdef ESCALONADOR_ACELERA_EN
        val = COOLDOWN - 8 * (N - $countones(v));
        if (val < 8) val = 8;
`endif
        return val;
    endfunction

    function automatic model_t model_next(model_t c, logic rst, logic pa, logic tk,
                                          logic [N-1:0] v, logic [N-1:0] bl);
        model_t n;
        bit     achou;
        int     j;
        n = c;
        if (rst) begin
            n.fase  = 0;
            n.resta = COOLDOWN;
            n.ticks = 0;
            n.idx   = N - 1;
            n.fire  = 1'b0;
        end else if (!pa) begin
            if (c.fase == 0) begin
                if (tk) begin
                    n.resta = c.resta - 1;
                    if (n.resta <= 0) begin
                        n.resta = 0;
                        n.fase  = 1;
                    end
                end
            end else if (c.fase == 1) begin
                achou = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    j = (c.idx + k) % N;
                    if (!achou && v[j] && bl[j]) begin
                        achou   = 1'b1;
                        n.idx   = j;
                        n.fire  = 1'b1;
                        n.ticks = 0;
                        n.fase  = 2;
                    end
                end
            end else begin
                if (!v[c.idx] || !bl[c.idx] || (tk && c.ticks + 1 >= TIMEOUT)) begin
                    n.fire  = 1'b0;
                    n.resta = cd_load(v);
                    n.fase  = 0;
                end else if (tk) begin
                    n.ticks = c.ticks + 1;
                end
            end
        end
        return n;
    endfunction

    always @(posedge CLOCK_50) begin
        m <= model_next(m, reset || reiniciarJogo, pausa, tick_mv, vivo, bola_livre);
    end

    task automatic checkOutput(input string nome, input int atual, input int esperado);
        checks++;
        if (atual != esperado) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", nome, atual, esperado, $time);
        end
    endtask

    // Every cycle after reset the outputs must match the model.
    always @(negedge CLOCK_50) begin
        if (chk_en) begin
            logic [N-1:0] exp_d;
            exp_d = '0;
            if (m.fire) exp_d[m.idx] = 1'b1;
            checkOutput("model_disparo", int'(disparo), int'(exp_d));
            checkOutput("model_idx_atual", int'(idx_atual), m.idx);
            checkOutput("model_ocupado", int'(ocupado), (m.fase != 1) ? 1 : 0);
        end
    end

    task automatic applyStimulus(input logic tk);
        tick_mv = tk;
        @(negedge CLOCK_50);
        tick_mv = 1'b0;
    endtask

    task automatic tickN(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1);
            applyStimulus(1'b0);
        end
    endtask

    task automatic waitGrant(input string nome, input int esperado);
        int n;
        n = 0;
        while (disparo == '0 && n < 300) begin
            applyStimulus(1'b1);
            applyStimulus(1'b0);
            n++;
        end
        checkOutput(nome, n, esperado);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        chk_en        = 1'b0;
        reset         = 1'b1;
        reiniciarJogo = 1'b0;
        pausa         = 1'b0;
        tick_mv       = 1'b0;
        vivo          = 5'b11111;
        bola_livre    = 5'b11111;
        repeat (2) @(negedge CLOCK_50);
        chk_en = 1'b1;
        checkOutput("reset_disparo", int'(disparo), 0);
        checkOutput("reset_idx", int'(idx_atual), 4);
        checkOutput("reset_ocupado", int'(ocupado), 1);
        reset = 1'b0;

        // First grant lands on enemy 0 right after the 60th tick
        tickN(59);
        checkOutput("pre_grant_disparo", int'(disparo), 0);
        tick_mv = 1'b1;
        @(negedge CLOCK_50);
        tick_mv = 1'b0;
        checkOutput("escolhe_ocupado", int'(ocupado), 0);
        checkOutput("escolhe_disparo", int'(disparo), 0);
        @(negedge CLOCK_50);
        checkOutput("grant0_disparo", int'(disparo), 5'b00001);
        checkOutput("grant0_idx", int'(idx_atual), 0);

        // Acceptance drops the request the next cycle
        bola_livre = 5'b11110;
        applyStimulus(1'b0);
        checkOutput("accept0_disparo", int'(disparo), 0);
        bola_livre = 5'b11111;
        waitGrant("cooldown_full", 60);
        checkOutput("grant1_disparo", int'(disparo), 5'b00010);

        // Two enemies alive: skip the dead ones, wrap around
        bola_livre = 5'b11101;
        applyStimulus(1'b0);
        bola_livre = 5'b11111;
        vivo = 5'b10100;
        waitGrant("cooldown_after_all_alive", 60);
        checkOutput("grant2_disparo", int'(disparo), 5'b00100);
        checkOutput("grant2_idx", int'(idx_atual), 2);
        bola_livre = 5'b11011;
        applyStimulus(1'b0);
        bola_livre = 5'b11111;
        waitGrant("cooldown_two_alive", CD_DOIS);
        checkOutput("grant4_disparo", int'(disparo), 5'b10000);
        bola_livre = 5'b01111;
        applyStimulus(1'b0);
        bola_livre = 5'b11111;
        waitGrant("cooldown_two_alive_b", CD_DOIS);
        checkOutput("grant_wrap_disparo", int'(disparo), 5'b00100);

        // Kill the granted enemy before it accepts
        bola_livre = 5'b11011;
        applyStimulus(1'b0);
        bola_livre = 5'b11111;
        vivo = 5'b11111;
        waitGrant("cooldown_two_alive_c", CD_DOIS);
        checkOutput("grant3_disparo", int'(disparo), 5'b01000);
        vivo = 5'b10111;
        applyStimulus(1'b0);
        checkOutput("kill3_disparo", int'(disparo), 0);
        checkOutput("kill3_ocupado", int'(ocupado), 1);
        waitGrant("cooldown_after_kill", CD_QUATRO);
        checkOutput("grant4b_disparo", int'(disparo), 5'b10000);

        // Unaccepted grant is abandoned on the 4th tick
        tickN(3);
        checkOutput("timeout_held", int'(disparo), 5'b10000);
        tickN(1);
        checkOutput("timeout_drop", int'(disparo), 0);
        checkOutput("timeout_ocupado", int'(ocupado), 1);

        // Pause freezes the cooldown counter
        tickN(10);
        pausa = 1'b1;
        tickN(100);
        checkOutput("pause_disparo", int'(disparo), 0);
        checkOutput("pause_ocupado", int'(ocupado), 1);
        pausa = 1'b0;
        waitGrant("cooldown_after_pause", CD_QUATRO - 10);
        checkOutput("grant_after_pause", int'(disparo), 5'b00001);

        // Restart mid-grant, then everybody dead
        reiniciarJogo = 1'b1;
        applyStimulus(1'b0);
        reiniciarJogo = 1'b0;
        checkOutput("restart_disparo", int'(disparo), 0);
        checkOutput("restart_idx", int'(idx_atual), 4);
        checkOutput("restart_ocupado", int'(ocupado), 1);
        vivo = 5'b00000;
        tickN(60);
        repeat (20) applyStimulus(1'b0);
        checkOutput("all_dead_disparo", int'(disparo), 0);
        checkOutput("all_dead_ocupado", int'(ocupado), 0);
        vivo = 5'b11111;
        applyStimulus(1'b0);
        checkOutput("revive_disparo", int'(disparo), 5'b00001);
        checkOutput("revive_idx", int'(idx_atual), 0);

        chk_en = 1'b0;
        @(negedge CLOCK_50);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
